// File: rtl/common_pkg.sv
// Shared types for the SRAM arbiter: arbitration mode
// and the access sequencer state encoding.
package common;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority picker: first asserted req at or after
// base (wrapping), returned as onehot, index and valid.
module arb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   base,
  output logic [N-1:0] onehot,
  output logic [2:0]   id,
  output logic         any
);

  int best;
  int off;

  always_comb begin
    onehot = '0;
    id     = '0;
    best   = N;
    off    = 0;
    for (int i = 0; i < N; i++) begin
      off = (i + N - int'(base)) % N;
      if (req[i] && off < best) begin
        best      = off;
        id        = 3'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel SRAM arbiter: one SETUP/ACCESS/DONE
// sequence per grant, fixed or round-robin priority.
module mem_arbiter
  import common::*;
#(
  parameter int        NCH  = 4,
  parameter int        AW   = 19,
  parameter int        ACC  = 2,
  parameter arb_mode_t MODE = ARB_FIXED
) (
  input  logic                   clk28,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         lock,
  input  logic [NCH-1:0]         wr,
  input  logic [NCH-1:0][AW-1:0] addr,
  input  logic [NCH-1:0][7:0]    wdata,
  output logic [NCH-1:0]         ack,
  output logic [7:0]             rdata,
  output logic [AW-1:0]          va,
  output logic [7:0]             vd_out,
  output logic                   vd_oe,
  input  logic [7:0]             vd_in,
  output logic                   n_vrd,
  output logic                   n_vwr,
  output logic [2:0]             grant_id
);

  arb_state_t     state;
  logic [2:0]     cnt;
  logic [2:0]     last_grant;
  logic [NCH-1:0] gnt_oh;
  logic           wr_q;

  logic [NCH-1:0] cand;
  logic [2:0]     base;
  logic [NCH-1:0] pick_oh;
  logic [2:0]     pick_id;
  logic           pick_any;
  logic           regrant;
  logic [NCH-1:0] win_oh;
  logic [2:0]     win_id;
  logic           win_any;
  logic [AW-1:0]  sel_addr;
  logic [7:0]     sel_wdata;
  logic           sel_wr;

  // The channel just acked still shows req in DONE; that is not
  // a new request unless it holds lock.
  always_comb begin
    regrant = (state == S_DONE) && |(gnt_oh & lock & req);
    cand    = (state == S_DONE) ? (req & ~gnt_oh) : req;
    base    = 3'd0;
    if (MODE == ARB_RR)
      base = (last_grant == 3'(NCH - 1)) ? 3'd0 : last_grant + 3'd1;
  end

  arb_rr_pick #(.N(NCH)) u_pick (
    .req    (cand),
    .base   (base),
    .onehot (pick_oh),
    .id     (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    win_oh    = regrant ? gnt_oh : pick_oh;
    win_id    = regrant ? grant_id : pick_id;
    win_any   = regrant | pick_any;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (win_oh[i]) begin
        sel_addr  = addr[i];
        sel_wdata = wdata[i];
        sel_wr    = wr[i];
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= 3'(NCH - 1);
      gnt_oh     <= '0;
      wr_q       <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      va         <= '0;
      vd_out     <= '0;
      vd_oe      <= 1'b0;
      n_vrd      <= 1'b1;
      n_vwr      <= 1'b1;
      grant_id   <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        S_IDLE, S_DONE: begin
          n_vrd <= 1'b1;
          n_vwr <= 1'b1;
          if (win_any) begin
            state      <= S_SETUP;
            va         <= sel_addr;
            vd_out     <= sel_wdata;
            vd_oe      <= sel_wr;
            wr_q       <= sel_wr;
            gnt_oh     <= win_oh;
            grant_id   <= win_id;
            last_grant <= win_id;
          end else begin
            state  <= S_IDLE;
            va     <= '0;
            vd_out <= '0;
            vd_oe  <= 1'b0;
          end
        end
        S_SETUP: begin
          state <= S_ACCESS;
          cnt   <= 3'(ACC - 1);
          if (wr_q) n_vwr <= 1'b0;
          else      n_vrd <= 1'b0;
        end
        S_ACCESS: begin
          if (cnt == 3'd0) begin
            state <= S_DONE;
            n_vrd <= 1'b1;
            n_vwr <= 1'b1;
            ack   <= gnt_oh;
            rdata <= vd_in;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
